// File: rtl/uart_tx_arbiter.sv
// Round-robin, per-packet arbiter sharing one UART tx byte stream.
// Ports: i_req_* per-requester byte streams, o_tx_* to UART, grant/busy/timeout status.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter bit HEADER_EN      = 1'b1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic [NUM_REQ*8-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_busy,
  output logic                 o_timeout,
  output logic [3:0]           o_timeout_id
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } state_t;

  state_t        state, state_nx;
  logic [GW-1:0] gnt, gnt_nx;
  logic [GW-1:0] rr, rr_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          to_nx;
  logic [3:0]    to_id_nx;

  logic          pick_vld;
  logic [GW-1:0] pick;
  logic [GW-1:0] idx;

  logic          v_g;
  logic          l_g;
  logic [7:0]    d_g;

  // first valid requester searching upward from rr+1, wrapping
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = GW'((int'(rr) + i) % NUM_REQ);
      if (!pick_vld && i_req_valid[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  assign v_g = i_req_valid[gnt];
  assign l_g = i_req_last[gnt];
  assign d_g = i_req_data[{gnt, 3'b000} +: 8];

  assign o_busy  = (state != IDLE);
  assign o_grant = o_busy ? (ONE << gnt) : '0;

  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    rr_nx       = rr;
    cnt_nx      = cnt;
    to_nx       = 1'b0;
    to_id_nx    = o_timeout_id;
    o_tx_valid  = 1'b0;
    o_tx_data   = 8'h00;
    o_req_ready = '0;
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          gnt_nx = pick;
          if (HEADER_EN) state_nx = HEADER;
          else           state_nx = PAYLOAD;
        end
      end
      HEADER: begin
        o_tx_valid = 1'b1;
        o_tx_data  = 8'hF0 | 8'(gnt);
        if (i_tx_ready) state_nx = PAYLOAD;
      end
      PAYLOAD: begin
        o_tx_valid       = v_g;
        o_tx_data        = d_g;
        o_req_ready[gnt] = i_tx_ready;
        if (v_g && i_tx_ready) begin
          cnt_nx = '0;
          if (l_g) begin
            state_nx = IDLE;
            rr_nx    = gnt;
          end
        end else if (!v_g && TIMEOUT_CYCLES != 0) begin
          // stalled with valid high waits on the UART, not counted
          if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state_nx = IDLE;
            rr_nx    = gnt;
            cnt_nx   = '0;
            to_nx    = 1'b1;
            to_id_nx = 4'(gnt);
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      gnt          <= '0;
      rr           <= GW'(NUM_REQ - 1);
      cnt          <= '0;
      o_timeout    <= 1'b0;
      o_timeout_id <= 4'h0;
    end else begin
      state        <= state_nx;
      gnt          <= gnt_nx;
      rr           <= rr_nx;
      cnt          <= cnt_nx;
      o_timeout    <= to_nx;
      o_timeout_id <= to_id_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed boundary cases plus a
// randomized run against a queue-level round-robin reference.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          rst_n;
  logic [N*8-1:0] req_data;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [N-1:0]  grant;
  logic          busy;
  logic          timeout;
  logic [3:0]    timeout_id;

  int vectors = 0;
  int errors  = 0;
  int to_cnt  = 0;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .HEADER_EN(1'b1),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clock(clk),
    .i_reset_n(rst_n),
    .i_req_data(req_data),
    .i_req_valid(req_valid),
    .i_req_last(req_last),
    .o_req_ready(req_ready),
    .o_tx_data(tx_data),
    .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready),
    .o_grant(grant),
    .o_busy(busy),
    .o_timeout(timeout),
    .o_timeout_id(timeout_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (timeout) to_cnt++;

  initial begin
    #400000;
    $display("FAIL global_time_limit");
    $fatal(1);
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(int k, logic [7:0] d, logic l);
    req_valid[k]       = 1'b1;
    req_data[8*k +: 8] = d;
    req_last[k]        = l;
  endtask

  task automatic undrv(int k);
    req_valid[k] = 1'b0;
    req_last[k]  = 1'b0;
  endtask

  logic [8:0] pq [N][$];
  logic [7:0] obs [$];
  logic [7:0] expq [$];
  int ptr [N];
  int gap [N];
  int mp [N];

  initial begin
    int n0;
    int rr;
    int sel;
    bit any;
    bit lst;
    bit done;
    bit prev_stall;
    logic [7:0] prev_data;

    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_ready  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_to", timeout, 0);
    chk("rst_toid", timeout_id, 0);
    rst_n = 1'b1;

    // single requester, header then two bytes
    @(negedge clk); tx_ready = 1'b1; drv(0, 8'h41, 1'b0);
    #1 chk("t1_idle_grant", grant, 0);
    @(negedge clk); #1;
    chk("t1_hdr_grant", grant, 4'b0001);
    chk("t1_hdr_busy", busy, 1);
    chk("t1_hdr_txv", tx_valid, 1);
    chk("t1_hdr_txd", tx_data, 8'hF0);
    chk("t1_hdr_ready", req_ready, 0);
    @(negedge clk); #1;
    chk("t1_b0_txd", tx_data, 8'h41);
    chk("t1_b0_ready", req_ready, 4'b0001);
    @(negedge clk); drv(0, 8'h42, 1'b1);
    #1 chk("t1_b1_txd", tx_data, 8'h42);
    @(negedge clk); undrv(0);
    #1;
    chk("t1_end_grant", grant, 0);
    chk("t1_end_busy", busy, 0);

    // watchdog abort of req1, waiting req3 served next
    @(negedge clk); drv(1, 8'h10, 1'b0); drv(3, 8'h33, 1'b1);
    @(negedge clk); #1;
    chk("t3_hdr_grant", grant, 4'b0010);
    chk("t3_hdr_txd", tx_data, 8'hF1);
    @(negedge clk); #1 chk("t3_b0_txd", tx_data, 8'h10);
    @(negedge clk); undrv(1);
    repeat (7) @(negedge clk);
    #1;
    chk("t3_pre_to", timeout, 0);
    chk("t3_pre_grant", grant, 4'b0010);
    @(negedge clk); #1;
    chk("t3_to", timeout, 1);
    chk("t3_toid", timeout_id, 1);
    chk("t3_to_grant", grant, 0);
    @(negedge clk); #1;
    chk("t3_to_pulse", timeout, 0);
    chk("t3_next_grant", grant, 4'b1000);
    chk("t3_next_txd", tx_data, 8'hF3);
    chk("t3_toid_hold", timeout_id, 1);
    @(negedge clk); #1;
    chk("t3_r3_txd", tx_data, 8'h33);
    chk("t3_r3_ready", req_ready, 4'b1000);
    @(negedge clk); undrv(3);
    #1 chk("t3_end_grant", grant, 0);

    // valid returns on the cycle the count would hit the limit
    n0 = to_cnt;
    @(negedge clk); drv(1, 8'h20, 1'b0);
    @(negedge clk);
    @(negedge clk); #1 chk("t4_b0_txd", tx_data, 8'h20);
    @(negedge clk); undrv(1);
    repeat (6) @(negedge clk);
    @(negedge clk); drv(1, 8'h21, 1'b0);
    #1;
    chk("t4_b1_txv", tx_valid, 1);
    chk("t4_b1_grant", grant, 4'b0010);
    @(negedge clk); undrv(1);
    repeat (6) @(negedge clk);
    @(negedge clk); drv(1, 8'h22, 1'b1);
    #1 chk("t4_b2_grant", grant, 4'b0010);
    @(negedge clk); undrv(1);
    #1;
    chk("t4_end_grant", grant, 0);
    chk("t4_no_timeout", to_cnt - n0, 0);

    // asynchronous reset mid-payload of req2
    @(negedge clk); drv(2, 8'h55, 1'b0);
    @(negedge clk); #1 chk("t5_hdr_txd", tx_data, 8'hF2);
    @(negedge clk);
    @(negedge clk); drv(2, 8'h56, 1'b0); tx_ready = 1'b0;
    #1 chk("t5_pre_txv", tx_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_txv", tx_valid, 0);
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_busy", busy, 0);
    @(negedge clk); req_valid = '0; req_last = '0; rst_n = 1'b1;
    @(negedge clk); drv(0, 8'h77, 1'b1); drv(2, 8'h88, 1'b1); tx_ready = 1'b1;
    @(negedge clk); #1;
    chk("t5_first_txd", tx_data, 8'hF0);
    chk("t5_first_grant", grant, 4'b0001);
    @(negedge clk); #1 chk("t5_r0_txd", tx_data, 8'h77);
    @(negedge clk); undrv(0);
    #1 chk("t5_idle_grant", grant, 0);
    @(negedge clk); #1;
    chk("t5_bubble_txd", tx_data, 8'hF2);
    chk("t5_bubble_grant", grant, 4'b0100);
    @(negedge clk); #1 chk("t5_r2_txd", tx_data, 8'h88);
    @(negedge clk); undrv(2);

    // randomized traffic vs queue-level round-robin model
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) begin
      int np;
      np = $urandom_range(0, 4);
      for (int p = 0; p < np; p++) begin
        int len;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++)
          pq[k].push_back({b == len - 1, 8'($urandom)});
      end
      ptr[k] = 0;
      gap[k] = 0;
      mp[k]  = 0;
    end

    rr = N - 1;
    forever begin
      any = 1'b0;
      sel = 0;
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (rr + i) % N;
        if (!any && mp[k] < pq[k].size()) begin
          any = 1'b1;
          sel = k;
        end
      end
      if (!any) break;
      expq.push_back(8'hF0 | 8'(sel));
      lst = 1'b0;
      while (!lst) begin
        expq.push_back(pq[sel][mp[sel]][7:0]);
        lst = pq[sel][mp[sel]][8];
        mp[sel]++;
      end
      rr = sel;
    end

    n0 = to_cnt;
    done = 1'b0;
    prev_stall = 1'b0;
    prev_data = 8'h00;
    for (int cy = 0; cy < 5000 && !done; cy++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (gap[k] == 0 && ptr[k] < pq[k].size()) begin
          drv(k, pq[k][ptr[k]][7:0], pq[k][ptr[k]][8]);
        end else begin
          undrv(k);
        end
      end
      tx_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (prev_stall) begin
        chk("rnd_hold_txv", tx_valid, 1);
        chk("rnd_hold_txd", tx_data, prev_data);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) obs.push_back(tx_data);
      for (int k = 0; k < N; k++) begin
        if (gap[k] > 0) begin
          gap[k]--;
        end else if (req_valid[k] && req_ready[k]) begin
          if (!req_last[k]) gap[k] = $urandom_range(0, 3);
          ptr[k]++;
        end
      end
      done = !busy;
      for (int k = 0; k < N; k++)
        if (ptr[k] < pq[k].size()) done = 1'b0;
    end
    req_valid = '0;
    chk("rnd_done", done, 1);
    chk("rnd_len", obs.size(), expq.size());
    for (int i = 0; i < expq.size() && i < obs.size(); i++)
      chk($sformatf("rnd_byte%0d", i), obs[i], expq[i]);
    chk("rnd_no_timeout", to_cnt - n0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit byte stream between NUM_REQ packet sources, so several on-chip agents can emit framed traffic over the single serial link.
- Sits between the requesters and the UART transmitter's byte input, in the same clock domain as the system logic.
- Grants are per packet: a requester keeps the grant until it presents its last byte.
- Grants rotate round-robin, an optional channel-ID header byte precedes each packet, and a watchdog releases a requester that stalls mid-packet.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- HEADER_EN, 1, 1 = send header byte 8'hF0 | grant index before each packet; 0 = no header.
- TIMEOUT_CYCLES, 1024, cycles the granted requester may hold i_req_valid low mid-packet before its packet is aborted; 0 disables the watchdog.

Ports:
- i_clock  input  1  system clock
- i_reset_n  input  1  reset, asynchronous and active-low
- i_req_data  input  NUM_REQ*8  byte per requester; requester k uses bits [8k+7:8k]
- i_req_valid  input  NUM_REQ  per-requester byte valid
- i_req_last  input  NUM_REQ  byte is the last of its packet
- o_req_ready  output  NUM_REQ  per-requester byte accepted
- o_tx_data  output  8  byte to the UART transmitter
- o_tx_valid  output  1  o_tx_data valid
- i_tx_ready  input  1  UART transmitter accepts the byte
- o_grant  output  NUM_REQ  one-hot current grant; all zero when idle
- o_busy  output  1  a packet is in progress
- o_timeout  output  1  one-cycle pulse when a packet is aborted
- o_timeout_id  output  4  index of the aborted requester; holds until the next abort

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - state = IDLE, rr pointer = NUM_REQ-1.
  - o_grant = 0, o_busy = 0, o_tx_valid = 0, o_req_ready = 0, o_tx_data = 0.
  - o_timeout = 0, o_timeout_id = 0, watchdog count = 0.
  - Reset mid-packet drops the packet with no partial flush.
- Handshakes: a transfer occurs when valid and ready are both high on a rising edge. Once o_tx_valid is high, o_tx_data stays stable until i_tx_ready. Requesters obey the same rule.
- State IDLE:
  - o_tx_valid = 0, o_req_ready = 0.
  - If any i_req_valid is set, the arbiter picks the first set bit searching from rr+1 upward, with modulo NUM_REQ wrap.
  - The grant index is registered. Next state is HEADER if HEADER_EN, otherwise PAYLOAD.
  - Latency: o_grant and o_busy rise on the cycle after the valid is sampled.
- State HEADER:
  - o_tx_valid = 1, o_tx_data = 8'hF0 | g, o_req_ready = 0.
  - On i_tx_ready, next state is PAYLOAD.
- State PAYLOAD (g = granted index):
  - Combinational passthrough: o_tx_valid = i_req_valid[g], o_tx_data = i_req_data[g], o_req_ready[g] = i_tx_ready. All other ready bits are 0.
  - On a transfer with i_req_last[g] = 1: next state IDLE, rr = g, o_grant cleared.
  - Zero-bubble rule: another request can be granted on the cycle after IDLE is entered.
- Watchdog (PAYLOAD only):
  - The count increments on each cycle with i_req_valid[g] = 0, and clears on any transfer.
  - A low i_tx_ready with valid high does not count.
  - When the count reaches TIMEOUT_CYCLES:
    - o_timeout pulses for 1 cycle and o_timeout_id = g.
    - Next state IDLE, rr = g, count cleared.
    - No bytes are discarded from the requester; its later bytes are treated as a new packet.
  - A header already in flight is never aborted.
- Simultaneous events:
  - Valid arrives in the same cycle the count would reach the limit: the transfer wins and there is no timeout.
  - Requests arriving during a packet wait; there is no preemption.
- Single-byte packet (last on the first byte) is legal.
- Requester validity is not checked in HEADER. A requester that drops valid after being granted is covered by the watchdog.

Test Plan:
- Req0 only, HEADER_EN = 1, packet 8'h41, 8'h42 (last), i_tx_ready = 1 -> tx sequence F0, 41, 42; o_grant = 0001 from the cycle after valid; IDLE afterwards.
- Req0 and req2 both valid from reset with 2-byte packets -> req0 served first, then req2 (header F2). Repeated simultaneous traffic alternates 0, 2, 0, 2.
- i_tx_ready toggled 1-0-1 during header and payload -> o_tx_data stable while stalled, no byte lost or duplicated, watchdog count stays 0.
- TIMEOUT_CYCLES = 8; req1 sends 8'h10, then drops valid -> on the 8th idle cycle o_timeout = 1 for one cycle, o_timeout_id = 1, o_grant = 0. A waiting req3 is granted next.
- Req1 valid asserted exactly on the cycle the count would hit 8 -> transfer occurs, no o_timeout, count cleared.
- Reset asserted mid-payload of req2 -> o_tx_valid, o_grant and o_busy drop asynchronously. After release, the arbitration order starts from req0.
